// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the LSU-to-data-port round-robin arbiter:
//   FSM state encoding, the error read-data pattern returned on a watchdog
//   expiry, and width helpers used by the arbiter and its picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] MEM_ARB_ERR_DATA = 32'hDEAD_BEEF;

  localparam int MEM_ARB_WDOG_MIN_W = 8;
  localparam int MEM_ARB_WDOG_MAX_W = 16;

  // Index width for a vector of n requesters (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width: enough to hold limit-1, clamped to 8..16 bits.
  function automatic int wdog_width(input int limit);
    int w;
    w = $clog2(limit);
    if (w < MEM_ARB_WDOG_MIN_W) w = MEM_ARB_WDOG_MIN_W;
    if (w > MEM_ARB_WDOG_MAX_W) w = MEM_ARB_WDOG_MAX_W;
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority select. Searches req upward starting
//   at rr_ptr, wrapping at N, and reports the first set bit.
//   Ports:
//     req     in  N    request vector
//     rr_ptr  in  IDW  index with highest priority this round
//     any_req out 1    at least one request is set
//     winner  out IDW  index of the selected requester (0 when none)
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic           any_req,
  output logic [IDW-1:0] winner
);

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    sum     = '0;
    idx     = '0;
    any_req = 1'b0;
    winner  = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr+offset can exceed N before the wrap subtract.
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing the single DMEM/MMIO slave port between
//   NUM_MASTERS core LSUs. The winning request is registered onto the slave
//   port and held until s_ready; read data and a one-cycle m_ready pulse are
//   then returned to the winner.
//   Optional build macro: MEM_ARB_TIMEOUT_EN enables a BUSY watchdog that
//   completes a stuck access with m_err=1 and MEM_ARB_ERR_DATA after
//   TIMEOUT_CYCLES cycles. Without it m_err is constant 0.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     m_req/m_we [NM]                     per-master request / write flag
//     m_addr/m_wdata/m_be (packed)        per-master address/data/byte enables
//     m_ready [NM]                        one-hot completion pulse
//     m_rdata, m_err                      shared read data, access error
//     s_req/s_we/s_addr/s_wdata/s_be      slave request port
//     s_rdata, s_ready                    slave response
//     grant_id                            current or last granted master
//     busy                                FSM is not IDLE
//
//   state | meaning
//   IDLE  | arbitrate among m_req, register winner onto slave port
//   BUSY  | slave port held stable, waiting for s_ready (or watchdog)
//   RESP  | m_ready/m_rdata presented for one cycle, no arbitration
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_MASTERS-1:0]               m_req,
  input  logic [NUM_MASTERS-1:0]               m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_be,
  output logic [NUM_MASTERS-1:0]               m_ready,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic                                 m_err,
  output logic                                 s_req,
  output logic                                 s_we,
  output logic [ADDR_WIDTH-1:0]                s_addr,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  output logic [DATA_WIDTH/8-1:0]              s_be,
  input  logic [DATA_WIDTH-1:0]                s_rdata,
  input  logic                                 s_ready,
  output logic [idx_width(NUM_MASTERS)-1:0]    grant_id,
  output logic                                 busy
);

  localparam int IDW = idx_width(NUM_MASTERS);
  localparam int BW  = DATA_WIDTH / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_nm
    $error("mem_arbiter: NUM_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];
  logic [BW-1:0]         be_a    [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_a[g]    = m_be[g*BW +: BW];
  end

  arb_state_e             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   s_req_q, s_req_d;
  logic                   s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
  logic [BW-1:0]          s_be_q, s_be_d;
  logic [NUM_MASTERS-1:0] m_ready_q, m_ready_d;
  logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;

  logic                   any_req;
  logic [IDW-1:0]         winner;
  logic [NUM_MASTERS-1:0] grant_onehot;
  logic [IDW-1:0]         rr_next;

  rr_pick #(
    .N   (NUM_MASTERS),
    .IDW (IDW)
  ) u_rr_pick (
    .req     (m_req),
    .rr_ptr  (rr_ptr_q),
    .any_req (any_req),
    .winner  (winner)
  );

  assign grant_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_id_q;
  assign rr_next      = (grant_id_q == IDW'(NUM_MASTERS-1)) ? '0 : grant_id_q + IDW'(1);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WDW = wdog_width(TIMEOUT_CYCLES);
  // Down-counter loaded on BUSY entry; expiry when it has reached zero
  // and s_ready is still low, i.e. TIMEOUT_CYCLES cycles after s_req rose.
  localparam logic [WDW-1:0] WDOG_LOAD = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           m_err_q, m_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    s_req_d    = s_req_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_be_d     = s_be_q;
    m_ready_d  = '0;
    m_rdata_d  = m_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
    m_err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          s_req_d    = 1'b1;
          s_we_d     = m_we[winner];
          s_addr_d   = addr_a[winner];
          s_wdata_d  = wdata_a[winner];
          s_be_d     = be_a[winner];
          state_d    = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          wdog_d     = WDOG_LOAD;
`endif
        end
      end
      BUSY: begin
        if (s_ready) begin
          s_req_d   = 1'b0;
          m_rdata_d = s_we_q ? '0 : s_rdata;
          m_ready_d = grant_onehot;
          rr_ptr_d  = rr_next;
          state_d   = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wdog_q == '0) begin
          s_req_d   = 1'b0;
          m_rdata_d = DATA_WIDTH'(MEM_ARB_ERR_DATA);
          m_err_d   = 1'b1;
          m_ready_d = grant_onehot;
          rr_ptr_d  = rr_next;
          state_d   = RESP;
        end else begin
          wdog_d = wdog_q - WDW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      s_req_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_be_q     <= '0;
      m_ready_q  <= '0;
      m_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      s_req_q    <= s_req_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_be_q     <= s_be_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      m_err_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      m_err_q <= m_err_d;
    end
  end
  assign m_err = m_err_q;
`else
  assign m_err = 1'b0;
`endif

  assign s_req    = s_req_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_be     = s_be_q;
  assign m_ready  = m_ready_q;
  assign m_rdata  = m_rdata_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int NM = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [0:0]  grant_id;
  logic        busy;

  logic [31:0] addr_a  [NM];
  logic [31:0] wdata_a [NM];
  logic [3:0]  be_a    [NM];
  logic        we_a    [NM];
  logic [1:0]  req;

  assign m_req   = req;
  assign m_we    = {we_a[1], we_a[0]};
  assign m_addr  = {addr_a[1], addr_a[0]};
  assign m_wdata = {wdata_a[1], wdata_a[0]};
  assign m_be    = {be_a[1], be_a[0]};

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_be     (s_be),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    we_a[i]    = we;
    addr_a[i]  = a;
    wdata_a[i] = d;
    be_a[i]    = be;
  endtask

  task automatic rand_master(input int i);
    logic [31:0] a;
    a = ($urandom_range(0, 1) == 1) ? 32'h4000_0000 : ($urandom & 32'h01FF_FFFC);
    set_master(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)));
    req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference rule: first requester at or above ptr, wrapping.
  function automatic int pick(input logic [1:0] r, input int p);
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (p + k) % NM;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  initial begin
    int          g;
    int          n;
    int          ptr;
    int          ew;
    int          wait_left;
    logic        in_txn;
    logic        done_due;
    logic        grant_due;
    logic        saw_done;
    logic [1:0]  saved_req;
    logic [1:0]  completed;
    logic [1:0]  onehot;
    logic [31:0] last_rd;
    logic [31:0] erd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_we;

    rst_n = 1'b0;
    req = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < NM; i++) set_master(i, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    chk("rst_s_req", s_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_we", s_we, 0);
    rst_n = 1'b1;

    // single read with a two-cycle slave
    set_master(0, 1'b0, 32'h100, 32'h0, 4'hF);
    req = 2'b01;
    cycle();
    chk("rd_s_req", s_req, 1);
    chk("rd_s_addr", s_addr, 32'h100);
    chk("rd_s_we", s_we, 0);
    chk("rd_grant", grant_id, 0);
    chk("rd_busy", busy, 1);
    cycle();
    chk("rd_wait_s_req", s_req, 1);
    chk("rd_wait_m_ready", m_ready, 0);
    s_ready = 1'b1;
    s_rdata = 32'h1234_5678;
    cycle();
    chk("rd_m_ready", m_ready, 2'b01);
    chk("rd_m_rdata", m_rdata, 32'h1234_5678);
    chk("rd_s_req_drop", s_req, 0);
    req = 2'b00;
    s_ready = 1'b0;
    cycle();
    chk("rd_m_ready_clr", m_ready, 0);
    chk("rd_m_rdata_hold", m_rdata, 32'h1234_5678);
    chk("rd_busy_clr", busy, 0);

    // both masters continuously, zero-wait slave: alternating grants
    do_reset();
    set_master(0, 1'b0, 32'h200, 32'h0, 4'hF);
    set_master(1, 1'b0, 32'h300, 32'h0, 4'hF);
    req = 2'b11;
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_s_req", s_req, 1);
      chk("alt_grant", grant_id, g);
      chk("alt_s_addr", s_addr, (g == 0) ? 32'h200 : 32'h300);
      chk("alt_no_ready", m_ready, 0);
      cycle();
      chk("alt_m_ready", m_ready, (g == 0) ? 2'b01 : 2'b10);
      chk("alt_m_rdata", m_rdata, 32'h0BAD_F00D);
      if (k == 3) req = 2'b00;
      cycle();
      chk("alt_gap_ready", m_ready, 0);
      chk("alt_gap_s_req", s_req, 0);
      g = 1 - g;
    end

    // master 1 write to UART with a 10-cycle stall
    s_ready = 1'b0;
    set_master(1, 1'b1, 32'h4000_0000, 32'h41, 4'b0001);
    req = 2'b10;
    cycle();
    chk("wr_s_req", s_req, 1);
    chk("wr_s_we", s_we, 1);
    chk("wr_s_addr", s_addr, 32'h4000_0000);
    chk("wr_s_wdata", s_wdata, 32'h41);
    chk("wr_s_be", s_be, 4'b0001);
    chk("wr_grant", grant_id, 1);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("stall_s_req", s_req, 1);
      chk("stall_s_addr", s_addr, 32'h4000_0000);
      chk("stall_s_wdata", s_wdata, 32'h41);
      chk("stall_s_be", s_be, 4'b0001);
      chk("stall_s_we", s_we, 1);
      chk("stall_m_ready", m_ready, 0);
    end
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    cycle();
    chk("wr_m_ready", m_ready, 2'b10);
    chk("wr_m_rdata", m_rdata, 0);
    req = 2'b00;
    s_ready = 1'b0;
    cycle();
    chk("wr_m_ready_clr", m_ready, 0);

    // move rr_ptr to 1, then reset in the middle of a BUSY
    set_master(0, 1'b0, 32'h500, 32'h0, 4'hF);
    req = 2'b01;
    cycle();
    chk("pre_grant0", grant_id, 0);
    s_ready = 1'b1;
    cycle();
    chk("pre_m_ready", m_ready, 2'b01);
    req = 2'b00;
    s_ready = 1'b0;
    cycle();
    req = 2'b11;
    cycle();
    chk("mid_grant1", grant_id, 1);
    chk("mid_s_req", s_req, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_s_req", s_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_m_ready", m_ready, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_m_ready", m_ready, 0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_s_req", s_req, 1);
    chk("post_rst_m_ready", m_ready, 0);
    s_ready = 1'b1;
    cycle();
    chk("post_rst_done", m_ready, 2'b01);
    req = 2'b00;
    s_ready = 1'b0;
    cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // slave never answers: watchdog completes after 16 cycles
    set_master(0, 1'b0, 32'h600, 32'h0, 4'hF);
    req = 2'b01;
    cycle();
    chk("to_s_req", s_req, 1);
    n = 0;
    while (m_ready == 2'b00 && n < 40) begin
      cycle();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_m_ready", m_ready, 2'b01);
    chk("to_m_err", m_err, 1);
    chk("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
    req = 2'b00;
    cycle();
    chk("to_err_clr", m_err, 0);
    chk("to_ready_clr", m_ready, 0);
    set_master(1, 1'b0, 32'h700, 32'h0, 4'hF);
    req = 2'b10;
    s_ready = 1'b1;
    s_rdata = 32'h55;
    cycle();
    chk("to_next_grant", grant_id, 1);
    cycle();
    chk("to_next_ready", m_ready, 2'b10);
    chk("to_next_err", m_err, 0);
    chk("to_next_rdata", m_rdata, 32'h55);
    req = 2'b00;
    s_ready = 1'b0;
    cycle();
`endif

    // randomized traffic against a transaction-level model
    do_reset();
    req = '0;
    s_ready = 1'b0;
    ptr = 0;
    ew = 0;
    wait_left = 0;
    last_rd = '0;
    erd = '0;
    in_txn = 1'b0;
    done_due = 1'b0;
    grant_due = 1'b0;
    saved_req = '0;
    e_addr = '0;
    e_wdata = '0;
    e_be = '0;
    e_we = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cycle();
      completed = 2'b00;
      saw_done = 1'b0;
      if (done_due) begin
        onehot = '0;
        onehot[ew] = 1'b1;
        chk("rnd_m_ready", m_ready, onehot);
        chk("rnd_m_rdata", m_rdata, erd);
        chk("rnd_m_err", m_err, 0);
        chk("rnd_resp_s_req", s_req, 0);
        chk("rnd_resp_busy", busy, 1);
        ptr = (ew + 1) % NM;
        last_rd = erd;
        done_due = 1'b0;
        in_txn = 1'b0;
        completed[ew] = 1'b1;
        saw_done = 1'b1;
      end else begin
        chk("rnd_no_ready", m_ready, 0);
        chk("rnd_rdata_hold", m_rdata, last_rd);
      end
      if (grant_due) begin
        ew = pick(saved_req, ptr);
        chk("rnd_grant_s_req", s_req, 1);
        chk("rnd_grant_id", grant_id, ew);
        chk("rnd_grant_addr", s_addr, addr_a[ew]);
        chk("rnd_grant_we", s_we, we_a[ew]);
        chk("rnd_grant_wdata", s_wdata, wdata_a[ew]);
        chk("rnd_grant_be", s_be, be_a[ew]);
        e_addr = addr_a[ew];
        e_wdata = wdata_a[ew];
        e_be = be_a[ew];
        e_we = we_a[ew];
        in_txn = 1'b1;
        grant_due = 1'b0;
        wait_left = $urandom_range(0, 3);
      end else if (in_txn) begin
        chk("rnd_hold_s_req", s_req, 1);
        chk("rnd_hold_addr", s_addr, e_addr);
        chk("rnd_hold_wdata", s_wdata, e_wdata);
        chk("rnd_hold_be", s_be, e_be);
        chk("rnd_hold_we", s_we, e_we);
        chk("rnd_hold_grant", grant_id, ew);
      end else begin
        chk("rnd_idle_s_req", s_req, 0);
      end

      if (in_txn) begin
        s_rdata = $urandom;
        if (wait_left == 0) begin
          s_ready = 1'b1;
          erd = e_we ? 32'h0 : s_rdata;
          done_due = 1'b1;
        end else begin
          wait_left--;
          s_ready = 1'b0;
        end
      end else begin
        s_ready = 1'($urandom_range(0, 1));
        s_rdata = $urandom;
      end

      for (int i = 0; i < NM; i++) begin
        if (completed[i]) begin
          if ($urandom_range(0, 1) == 1) rand_master(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          rand_master(i);
        end
      end
      grant_due = !in_txn && !saw_done && (req != 2'b00);
      saved_req = req;
    end

    req = '0;
    s_ready = 1'b0;
    repeat (4) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter sharing the single data-memory/MMIO port (DMEM below 0x0200_0000, UART at 0x4000_0000) between NUM_MASTERS core LSUs in the multicore build.
- Latches the winning request, drives the slave port until the slave handshakes, then returns read data and a one-cycle completion pulse to the winner.
- Sits between the per-core load/store units and the dmem/uart_sim address decode.

Parameters:
- NUM_MASTERS, 2, number of requesting cores; 2..8.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- TIMEOUT_CYCLES, 256, watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held high until that master's m_ready.
- m_we  in  NUM_MASTERS  per-master write flag.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*AW +: AW].
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_be  in  NUM_MASTERS*DATA_WIDTH/8  packed byte enables.
- m_ready  out  NUM_MASTERS  one-hot completion pulse.
- m_rdata  out  DATA_WIDTH  read data shared by all masters; valid while m_ready is high.
- m_err  out  1  access error; qualifies m_ready.
- s_req  out  1  slave request.
- s_we  out  1  slave write flag.
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_be  out  DATA_WIDTH/8  slave byte enables.
- s_rdata  in  DATA_WIDTH  slave read data; valid when s_ready is high.
- s_ready  in  1  slave completion; sampled only while s_req is high.
- grant_id  out  $clog2(NUM_MASTERS)  index of the current or last granted master.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; state IDLE; rr_ptr 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any m_req bit is set, pick the winner: the first set bit searching from rr_ptr upward, wrapping at NUM_MASTERS.
  - Register the winner's we/addr/wdata/be onto the s_* outputs, set grant_id, set s_req=1, go to BUSY.
  - If no m_req bit is set, stay in IDLE.
- BUSY:
  - s_* outputs are held stable.
  - On s_ready=1 (same edge): latch s_rdata into m_rdata (latch 0 for writes), s_req=0, set m_ready[grant_id]=1, set rr_ptr=(grant_id+1) mod NUM_MASTERS, go to RESP.
- RESP: m_ready is high for exactly this cycle; it clears on the next edge and the state returns to IDLE. No new arbitration happens in RESP.
- Latency: m_req rising to s_req is 1 cycle. s_ready to m_ready is 1 cycle.
- Throughput: a zero-wait slave gives one transaction per 3 cycles.
- Simultaneous requests: round-robin guarantees each requester is served within NUM_MASTERS grants.
- Single requester: served repeatedly; rr_ptr still advances.
- m_req dropping while in BUSY: protocol violation. The transaction still completes and m_ready still pulses.
- A master re-asserting m_req in the cycle after its m_ready is a new request.
- s_ready while s_req=0: ignored.
- Asynchronous reset mid-transaction: s_req drops immediately, the transaction is lost, and no m_ready is issued.
- m_rdata holds its value between completions.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: an 8..16-bit watchdog counts BUSY cycles. When the count reaches TIMEOUT_CYCLES-1 without s_ready:
  - s_req=0, m_rdata=32'hDEAD_BEEF, m_err=1, m_ready[grant_id]=1;
  - go to RESP and advance rr_ptr.
  - m_err clears with m_ready.
  - The counter clears on entry to BUSY.
- Not defined: m_err is tied 0, no counter exists, and BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - MEM_ARB_ERR_DATA=32'hDEAD_BEEF;
  - helper width localparams.
- Sub-module rr_pick: combinational round-robin priority select. Inputs: req vector and rr_ptr. Outputs: any_req and winner index.

Test Plan:
- Reset, then m_req=2'b01, m_we=0, m_addr[0]=0x100, slave returns s_rdata=0x12345678 with s_ready 2 cycles after s_req -> s_addr=0x100 one cycle after m_req; m_ready=2'b01 and m_rdata=0x12345678 exactly one cycle after s_ready.
- Both masters request continuously, zero-wait slave -> grants alternate 0,1,0,1; grant_id sequence 0,1,0,1; one m_ready pulse every 3 cycles.
- Master 1 writes addr 0x4000_0000, wdata 0x41, be 4'b0001 -> s_we=1, s_wdata=0x41, s_be=4'b0001; m_rdata=0 at completion.
- Slave holds s_ready=0 for 10 cycles in BUSY, then pulses it -> s_* outputs stable for all 10 cycles; exactly one m_ready.
- rst_n driven low during BUSY -> s_req=0 and busy=0 immediately; after release, rr_ptr=0 and a pending m_req=2'b11 is granted to master 0.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never ready -> m_ready pulses 16 cycles after s_req rises, with m_err=1 and m_rdata=0xDEADBEEF; the next request is served normally.
